// File: rtl/arbitro_perfil_if.sv
// arbitro_perfil_if
//   Bundles the selector-side requests/codes and the decoder-side outputs of
//   the profile arbiter.
//   master : drives req1/cod1/req2/cod2/prio2, observes cod_out/valid/gnt/troca
//   slave  : the arbiter itself
interface arbitro_perfil_if;
  logic       req1;
  logic [2:0] cod1;
  logic       req2;
  logic [2:0] cod2;
  logic       prio2;
  logic [2:0] cod_out;
  logic       valid;
  logic [1:0] gnt;
  logic       troca;

  modport master (
    output req1, cod1, req2, cod2, prio2,
    input  cod_out, valid, gnt, troca
  );

  modport slave (
    input  req1, cod1, req2, cod2, prio2,
    output cod_out, valid, gnt, troca
  );
endinterface

// File: rtl/arbitro_perfil.sv
// arbitro_perfil
//   Arbitrates between two profile selectors sharing the final code decoder.
//   One profile is granted at a time; its code is forwarded (registered) to
//   the decoder. Every handover passes through a one-cycle PAUSA slot in which
//   nothing is forwarded and troca pulses.
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   bus (slave)  req1/cod1, req2/cod2, prio2 in; cod_out, valid, gnt, troca out
// Parameters
//   MIN_HOLD  grant cycles before profile-2 priority may preempt (>=1)
//   MAX_HOLD  grant cycles after which a waiting opponent takes over; 0 = never
//   CNT_W     grant counter width; must hold max(MIN_HOLD, MAX_HOLD)
// Build option
//   PRIO_PREEMPT_EN : when defined, req2 with prio2 preempts G1 once the grant
//                     has lasted MIN_HOLD cycles. Otherwise prio2 only breaks
//                     ties during arbitration.
module arbitro_perfil #(
  parameter int MIN_HOLD = 4,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input logic              clk,
  input logic              rst,
  arbitro_perfil_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, G1, G2, PAUSA} estado_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
`ifdef PRIO_PREEMPT_EN
  localparam logic [CNT_W-1:0] PRE     = CNT_W'(MIN_HOLD - 1);
`endif

  estado_t          estado;
  logic [CNT_W-1:0] cnt;
  logic             last_p2;   // profile served last: 1 = profile 2

  logic       pick1, pick2;
  logic       own_req, opp_req;
  logic [2:0] own_cod;
  logic       timeout, preempt;

  // Arbitration outcome for IDLE/PAUSA: prio2 wins ties, else round robin
  always_comb begin
    pick1 = 1'b0;
    pick2 = 1'b0;
    if (bus.req1 && bus.req2) begin
      pick2 = bus.prio2 || !last_p2;
      pick1 = !pick2;
    end else begin
      pick1 = bus.req1;
      pick2 = bus.req2;
    end
  end

  // View of the granted profile and its opponent
  always_comb begin
    own_req = bus.req1;
    opp_req = bus.req2;
    own_cod = bus.cod1;
    if (estado == G2) begin
      own_req = bus.req2;
      opp_req = bus.req1;
      own_cod = bus.cod2;
    end
  end

  assign timeout = (MAX_HOLD != 0) && (cnt >= TMO) && opp_req;

`ifdef PRIO_PREEMPT_EN
  assign preempt = (estado == G1) && bus.req2 && bus.prio2 && (cnt >= PRE);
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      estado      <= IDLE;
      cnt         <= '0;
      last_p2     <= 1'b1;
      bus.cod_out <= 3'b000;
      bus.valid   <= 1'b0;
      bus.gnt     <= 2'b00;
      bus.troca   <= 1'b0;
    end else begin
      bus.troca <= 1'b0;
      case (estado)
        IDLE, PAUSA: begin
          cnt <= '0;
          if (pick1) begin
            estado      <= G1;
            bus.gnt     <= 2'b01;
            bus.valid   <= 1'b1;
            bus.cod_out <= bus.cod1;
          end else if (pick2) begin
            estado      <= G2;
            bus.gnt     <= 2'b10;
            bus.valid   <= 1'b1;
            bus.cod_out <= bus.cod2;
          end else begin
            estado      <= IDLE;
            bus.gnt     <= 2'b00;
            bus.valid   <= 1'b0;
            bus.cod_out <= 3'b000;
          end
        end
        default: begin  // G1 / G2
          // Release outranks preemption and timeout; all handovers via PAUSA
          if ((!own_req && opp_req) || (own_req && (preempt || timeout))) begin
            estado      <= PAUSA;
            bus.troca   <= 1'b1;
            bus.gnt     <= 2'b00;
            bus.valid   <= 1'b0;
            bus.cod_out <= 3'b000;
            last_p2     <= (estado == G2);
          end else if (!own_req) begin
            estado      <= IDLE;
            bus.gnt     <= 2'b00;
            bus.valid   <= 1'b0;
            bus.cod_out <= 3'b000;
          end else begin
            bus.cod_out <= own_cod;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_perfil.sv
module tb_arbitro_perfil;

  localparam int MIN_HOLD = 4;
  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 5;
`ifdef PRIO_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arbitro_perfil_if bus ();

  arbitro_perfil #(
    .MIN_HOLD (MIN_HOLD),
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the decoder, for how many cycles, who went last
  int         owner = 0;     // 0 = nobody (idle or pause), 1 / 2 = profile
  int         held  = 0;     // completed grant cycles of the current owner
  int         last  = 2;
  logic [2:0] e_cod   = 3'b000;
  logic       e_vld   = 1'b0;
  logic [1:0] e_gnt   = 2'b00;
  logic       e_troca = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit q1, input logic [2:0] c1,
                       input bit q2, input logic [2:0] c2, input bit p);
    int winner;
    int leave;   // 0 stay, 1 to idle, 2 handover slot
    bit mine, other;
    e_troca = 1'b0;
    if (r) begin
      owner = 0; held = 0; last = 2;
      e_cod = 3'b000; e_vld = 1'b0; e_gnt = 2'b00;
    end else if (owner == 0) begin
      winner = 0;
      if (q1 && q2)  winner = p ? 2 : ((last == 2) ? 1 : 2);
      else if (q1)   winner = 1;
      else if (q2)   winner = 2;
      owner = winner;
      held  = 0;
      if (winner == 0) begin
        e_cod = 3'b000; e_vld = 1'b0; e_gnt = 2'b00;
      end else begin
        e_cod = (winner == 1) ? c1 : c2;
        e_vld = 1'b1;
        e_gnt = (winner == 1) ? 2'b01 : 2'b10;
      end
    end else begin
      mine  = (owner == 1) ? q1 : q2;
      other = (owner == 1) ? q2 : q1;
      leave = 0;
      if (!mine)                                                   leave = other ? 2 : 1;
      else if (PREEMPT && owner == 1 && q2 && p && held >= MIN_HOLD - 1) leave = 2;
      else if (MAX_HOLD != 0 && held >= MAX_HOLD - 1 && other)     leave = 2;
      if (leave == 0) begin
        held++;
        e_cod = (owner == 1) ? c1 : c2;
      end else begin
        if (leave == 2) begin
          last    = owner;
          e_troca = 1'b1;
        end
        owner = 0;
        e_cod = 3'b000; e_vld = 1'b0; e_gnt = 2'b00;
      end
    end
  endtask

  task automatic step(input bit r, input bit q1, input logic [2:0] c1,
                      input bit q2, input logic [2:0] c2, input bit p);
    @(negedge clk);
    rst       = r;
    bus.req1  = q1;
    bus.cod1  = c1;
    bus.req2  = q2;
    bus.cod2  = c2;
    bus.prio2 = p;
    @(posedge clk);
    model(r, q1, c1, q2, c2, p);
    #1;
    chk("cod_out", 32'(bus.cod_out), 32'(e_cod));
    chk("valid",   32'(bus.valid),   32'(e_vld));
    chk("gnt",     32'(bus.gnt),     32'(e_gnt));
    chk("troca",   32'(bus.troca),   32'(e_troca));
  endtask

  initial begin
    bit         q1, q2, p, r;
    logic [2:0] c1, c2;
    bus.req1 = 1'b0; bus.cod1 = 3'b000;
    bus.req2 = 1'b0; bus.cod2 = 3'b000;
    bus.prio2 = 1'b0;

    // Reset then quiet
    step(1, 0, 3'b000, 0, 3'b000, 0);
    step(1, 0, 3'b000, 0, 3'b000, 0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 3'b000, 0, 3'b000, 0);

    // Single request, code tracking
    for (int i = 0; i < 3; i++) step(0, 1, 3'b101, 0, 3'b000, 0);
    chk("g1_code", 32'(bus.cod_out), 32'd5);
    for (int i = 0; i < 3; i++) step(0, 1, 3'b010, 0, 3'b000, 0);
    step(0, 0, 3'b000, 0, 3'b000, 0);

    // Both requests, round robin with timeouts
    step(1, 0, 3'b000, 0, 3'b000, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 3'(i), 1, 3'(7 - i), 0);
    for (int i = 0; i < 2; i++) step(0, 0, 3'b000, 0, 3'b000, 0);

    // prio2 tie-break, then release of G2 with profile 1 waiting
    for (int i = 0; i < 5; i++) step(0, 1, 3'b001, 1, 3'b110, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 3'b001, 0, 3'b110, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 3'b000, 0, 3'b000, 0);

    // G1 running, profile 2 arrives with priority
    for (int i = 0; i < 2; i++) step(0, 1, 3'b011, 0, 3'b000, 0);
    for (int i = 0; i < 22; i++) step(0, 1, 3'b011, 1, 3'b100, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 3'b000, 0, 3'b000, 0);

    // Reset in the middle of G2
    for (int i = 0; i < 3; i++) step(0, 0, 3'b000, 1, 3'b111, 0);
    step(0, 1, 3'b001, 1, 3'b111, 0);
    step(1, 1, 3'b001, 1, 3'b111, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'b001, 1, 3'b111, 0);

    // Randomized traffic with sticky requests so timeouts occur
    q1 = 0; q2 = 0; p = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0)  q1 = ~q1;
      if ($urandom_range(0, 9) == 0)  q2 = ~q2;
      if ($urandom_range(0, 15) == 0) p  = ~p;
      if ($urandom_range(0, 1) == 0)  c1 = 3'($urandom);
      if ($urandom_range(0, 1) == 0)  c2 = 3'($urandom);
      r = ($urandom_range(0, 299) == 0);
      step(r, q1, c1, q2, c2, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
